// File: rtl/chirp_lfo_multi.sv
// -----------------------------------------------------------------------------
// chirp_lfo_multi
//   Multi-channel LFO-modulated chirp generator. Each channel owns a config
//   (rate, depth, offset, waveform mode), an LFO phase accumulator and a
//   carrier phase accumulator. A single time-shared datapath visits active
//   channels round-robin; every visit yields one output beat whose frequency
//   is offset + depth * waveform(LFO) and whose phase is the carrier phase
//   before that frequency is added.
//
// Ports
//   clk, reset         clock, asynchronous active-high reset
//   enable             low = synchronous clear back to the reset state
//   cfg_ch/rate/depth/offset/mode, cfg_valid/cfg_ready
//                      per-channel configuration handshake
//   dout_phase, dout_freq, dout_ch, dout_valid/dout_ready
//                      output beat handshake
// -----------------------------------------------------------------------------
module chirp_lfo_multi #(
  parameter int G_DIN_WIDTH   = 24,
  parameter int G_PHASE_WIDTH = 24,
  parameter int G_NUM_CH      = 2,
  localparam int CW = (G_NUM_CH > 1) ? $clog2(G_NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [CW-1:0]            cfg_ch,
  input  logic [G_DIN_WIDTH-1:0]   cfg_rate,
  input  logic [G_DIN_WIDTH-1:0]   cfg_depth,
  input  logic [G_DIN_WIDTH-1:0]   cfg_offset,
  input  logic [1:0]               cfg_mode,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  output logic [G_PHASE_WIDTH-1:0] dout_phase,
  output logic [G_DIN_WIDTH-1:0]   dout_freq,
  output logic [CW-1:0]            dout_ch,
  output logic                     dout_valid,
  input  logic                     dout_ready
);

  localparam int DW  = G_DIN_WIDTH;
  localparam int PW  = G_PHASE_WIDTH;
  localparam int PRW = 2 * DW + 1;

  typedef enum logic [2:0] {
    SM_IDLE, SM_SELECT, SM_LFO, SM_SCALE, SM_ACCUM, SM_OUT
  } state_t;

  // Waveform shaping from the raw LFO accumulator.
  function automatic logic signed [DW-1:0] wave(input logic [DW-1:0] a,
                                                input logic [1:0]    mode);
    logic [DW-1:0] x;
    logic [DW-1:0] t;
    x = a << 1;
    t = a[DW-1] ? ~x : x;
    case (mode)
      2'd0:    wave = {~t[DW-1], t[DW-2:0]};
      2'd1:    wave = a;
      2'd2:    wave = a[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      default: wave = '0;
    endcase
  endfunction

  // Q0.DW gain: full product, floor via arithmetic shift, keep low DW bits.
  function automatic logic signed [DW-1:0] scale(input logic signed [DW-1:0] w,
                                                 input logic [DW-1:0]        depth);
    logic signed [PRW-1:0] we;
    logic signed [PRW-1:0] de;
    logic signed [PRW-1:0] p;
    logic signed [PRW-1:0] sh;
    we = PRW'(w);
    de = PRW'($signed({1'b0, depth}));
    p  = we * de;
    sh = p >>> DW;
    scale = sh[DW-1:0];
  endfunction

  // Signed add with saturation to the DW range.
  function automatic logic signed [DW-1:0] sat_add(input logic signed [DW-1:0] s,
                                                   input logic signed [DW-1:0] o);
    logic [DW:0] sum;
    sum = {s[DW-1], s} + {o[DW-1], o};
    if (sum[DW] != sum[DW-1])
      sat_add = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else
      sat_add = sum[DW-1:0];
  endfunction

  // Control / state registers
  state_t                 state_q, state_d;
  logic [CW-1:0]          ptr_q, ptr_d;
  logic                   cfg_ready_q, cfg_ready_d;
  logic [G_NUM_CH-1:0]    active_q, active_d;
  logic [DW-1:0]          lfo_q [G_NUM_CH];
  logic [DW-1:0]          lfo_d [G_NUM_CH];
  logic [PW-1:0]          car_q [G_NUM_CH];
  logic [PW-1:0]          car_d [G_NUM_CH];
  logic [PW-1:0]          dout_phase_q, dout_phase_d;
  logic signed [DW-1:0]   dout_freq_q, dout_freq_d;
  logic [CW-1:0]          dout_ch_q, dout_ch_d;
  logic                   dout_valid_q, dout_valid_d;

  // Data registers (no reset needed: only read for active channels / in-flight)
  logic signed [DW-1:0]   rate_q   [G_NUM_CH];
  logic signed [DW-1:0]   rate_d   [G_NUM_CH];
  logic [DW-1:0]          depth_q  [G_NUM_CH];
  logic [DW-1:0]          depth_d  [G_NUM_CH];
  logic signed [DW-1:0]   offset_q [G_NUM_CH];
  logic signed [DW-1:0]   offset_d [G_NUM_CH];
  logic [1:0]             mode_q   [G_NUM_CH];
  logic [1:0]             mode_d   [G_NUM_CH];
  logic signed [DW-1:0]   w_q, w_d;
  logic signed [DW-1:0]   s_q, s_d;

  logic                   cfg_acc;
  logic                   cfg_in_range;
  logic                   nxt_found;
  logic [CW-1:0]          nxt_ptr;
  logic [CW-1:0]          cand;
  logic signed [DW-1:0]   f_sat;

  assign cfg_acc      = cfg_valid && cfg_ready_q;
  assign cfg_in_range = int'(cfg_ch) < G_NUM_CH;

  // Next active channel strictly after ptr; ptr itself is the last candidate.
  always_comb begin
    nxt_found = 1'b0;
    nxt_ptr   = ptr_q;
    cand      = '0;
    for (int i = 1; i <= G_NUM_CH; i++) begin
      cand = CW'((int'(ptr_q) + i) % G_NUM_CH);
      if (!nxt_found && active_q[cand]) begin
        nxt_found = 1'b1;
        nxt_ptr   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    active_d     = active_q;
    lfo_d        = lfo_q;
    car_d        = car_q;
    rate_d       = rate_q;
    depth_d      = depth_q;
    offset_d     = offset_q;
    mode_d       = mode_q;
    w_d          = w_q;
    s_d          = s_q;
    f_sat        = '0;
    dout_phase_d = dout_phase_q;
    dout_freq_d  = dout_freq_q;
    dout_ch_d    = dout_ch_q;
    dout_valid_d = dout_valid_q;

    case (state_q)
      SM_IDLE: begin
        if (cfg_acc) state_d = SM_SELECT;
      end
      SM_SELECT: begin
        // With nothing active (e.g. only out-of-range configs) fall back to idle.
        if (!cfg_acc) begin
          if (nxt_found) begin
            ptr_d   = nxt_ptr;
            state_d = SM_LFO;
          end else begin
            state_d = SM_IDLE;
          end
        end
      end
      // ---- stage: waveform from pre-increment LFO phase ----
      SM_LFO: begin
        w_d            = wave(lfo_q[ptr_q], mode_q[ptr_q]);
        lfo_d[ptr_q]   = lfo_q[ptr_q] + $unsigned(rate_q[ptr_q]);
        state_d        = SM_SCALE;
      end
      // ---- stage: depth scaling ----
      SM_SCALE: begin
        s_d     = scale(w_q, depth_q[ptr_q]);
        state_d = SM_ACCUM;
      end
      // ---- stage: offset, output load, carrier advance ----
      SM_ACCUM: begin
        f_sat         = sat_add(s_q, offset_q[ptr_q]);
        dout_freq_d   = f_sat;
        dout_phase_d  = car_q[ptr_q];
        dout_ch_d     = ptr_q;
        dout_valid_d  = 1'b1;
        car_d[ptr_q]  = car_q[ptr_q] + PW'(f_sat);
        state_d       = SM_OUT;
      end
      SM_OUT: begin
        if (dout_valid_q && dout_ready) begin
          dout_valid_d = 1'b0;
          state_d      = SM_SELECT;
        end
      end
      default: state_d = SM_IDLE;
    endcase

    // Config writes only happen in IDLE/SELECT, so they never collide with
    // the per-channel updates of the datapath states.
    if (cfg_acc && cfg_in_range) begin
      rate_d[cfg_ch]   = cfg_rate;
      depth_d[cfg_ch]  = cfg_depth;
      offset_d[cfg_ch] = cfg_offset;
      mode_d[cfg_ch]   = cfg_mode;
      active_d[cfg_ch] = 1'b1;
      lfo_d[cfg_ch]    = '0;
      car_d[cfg_ch]    = '0;
    end

    cfg_ready_d = (state_d == SM_IDLE) || (state_d == SM_SELECT);

    if (!enable) begin
      state_d      = SM_IDLE;
      ptr_d        = CW'(G_NUM_CH - 1);
      active_d     = '0;
      for (int i = 0; i < G_NUM_CH; i++) begin
        lfo_d[i] = '0;
        car_d[i] = '0;
      end
      dout_phase_d = '0;
      dout_freq_d  = '0;
      dout_ch_d    = '0;
      dout_valid_d = 1'b0;
      cfg_ready_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= SM_IDLE;
      ptr_q        <= CW'(G_NUM_CH - 1);
      cfg_ready_q  <= 1'b0;
      active_q     <= '0;
      for (int i = 0; i < G_NUM_CH; i++) begin
        lfo_q[i] <= '0;
        car_q[i] <= '0;
      end
      dout_phase_q <= '0;
      dout_freq_q  <= '0;
      dout_ch_q    <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cfg_ready_q  <= cfg_ready_d;
      active_q     <= active_d;
      lfo_q        <= lfo_d;
      car_q        <= car_d;
      dout_phase_q <= dout_phase_d;
      dout_freq_q  <= dout_freq_d;
      dout_ch_q    <= dout_ch_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    rate_q   <= rate_d;
    depth_q  <= depth_d;
    offset_q <= offset_d;
    mode_q   <= mode_d;
    w_q      <= w_d;
    s_q      <= s_d;
  end

  assign cfg_ready  = cfg_ready_q;
  assign dout_phase = dout_phase_q;
  assign dout_freq  = dout_freq_q;
  assign dout_ch    = dout_ch_q;
  assign dout_valid = dout_valid_q;

endmodule
